// File: rtl/pyramid_pkg.sv
// Shared widths and pixel arithmetic for the image-pyramid generator.
// Define PYR_ROUND_EN for round-to-nearest averaging; default build truncates.
package pyramid_pkg;

  localparam int unsigned PIX_IN_W = 12;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned SUM_W    = 10;
  localparam int unsigned H_W      = SUM_W - 1;

  // Reduce a 12-bit input pixel to the 8-bit L0 value.
  function automatic logic [PIX_W-1:0] l0_pix(input logic [PIX_IN_W-1:0] p);
`ifdef PYR_ROUND_EN
    logic [PIX_IN_W:0] r;
    r = (PIX_IN_W+1)'(p) + (PIX_IN_W+1)'(8);
    l0_pix = (r[PIX_IN_W:4] > 9'd255) ? 8'hFF : r[11:4];
`else
    l0_pix = PIX_W'(p >> 4);
`endif
  endfunction

  // Divide a 2x2 block sum by four.
  function automatic logic [PIX_W-1:0] avg4(input logic [SUM_W-1:0] sum);
`ifdef PYR_ROUND_EN
    logic [SUM_W:0] r;
    r = (SUM_W+1)'(sum) + (SUM_W+1)'(2);
    avg4 = (r[SUM_W:2] > 9'd255) ? 8'hFF : r[9:2];
`else
    avg4 = PIX_W'(sum >> 2);
`endif
  endfunction

endpackage

// File: rtl/pyr_down2x2.sv
// Streaming 2x2 box downsampler: pair register for horizontal sums,
// one-line buffer of horizontal sums for the vertical pass.
module pyr_down2x2
  import pyramid_pkg::*;
#(
  parameter int unsigned LINE_W    = 640,
  parameter int unsigned NUM_LINES = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] pix_o,
  output logic             valid_o
);

  localparam int unsigned CW    = $clog2(LINE_W);
  localparam int unsigned RW    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int unsigned BW    = CW - 1;
  localparam int unsigned BUF_N = LINE_W / 2;

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] pair_q, pair_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             valid_q, valid_d;

  logic [H_W-1:0]   lb_mem [BUF_N];
  logic [BW-1:0]    lb_idx;
  logic [H_W-1:0]   lb_rdata;
  logic             lb_we;
  logic [H_W-1:0]   h_sum;
  logic [SUM_W-1:0] s_sum;

  assign lb_idx   = col_q[CW-1:1];
  assign lb_rdata = lb_mem[lb_idx];
  assign h_sum    = H_W'(pair_q) + H_W'(pix_i);
  assign s_sum    = SUM_W'(h_sum) + SUM_W'(lb_rdata);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    pair_d  = pair_q;
    pix_d   = pix_q;
    valid_d = 1'b0;
    lb_we   = 1'b0;
    if (valid_i) begin
      if (col_q == CW'(LINE_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(NUM_LINES - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      // Even column latches the left pixel; odd column completes the pair.
      if (!col_q[0]) begin
        pair_d = pix_i;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        pix_d   = avg4(s_sum);
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
    end
  end

  // Line buffer contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (lb_we) lb_mem[lb_idx] <= h_sum;
  end

  assign pix_o   = pix_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pyramid_gen.sv
// Three-level streaming image pyramid (L0 full, L1 and L2 2x2 averages).
// Define PYR_ROUND_EN for rounded L0 reduction and averages.
module pyramid_gen
  import pyramid_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                addr_en,
  input  logic [PIX_IN_W-1:0] pixel_in,
  output logic [PIX_W-1:0]    pixout0,
  output logic [PIX_W-1:0]    pixout1,
  output logic [PIX_W-1:0]    pixout2,
  output logic                w_en0,
  output logic                w_en1,
  output logic                w_en2
);

  logic [PIX_W-1:0] pix0_q, pix0_d;
  logic             wen0_q, wen0_d;

  always_comb begin
    pix0_d = pix0_q;
    wen0_d = 1'b0;
    if (addr_en) begin
      pix0_d = l0_pix(pixel_in);
      wen0_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix0_q <= '0;
      wen0_q <= 1'b0;
    end else begin
      pix0_q <= pix0_d;
      wen0_q <= wen0_d;
    end
  end

  assign pixout0 = pix0_q;
  assign w_en0   = wen0_q;

  pyr_down2x2 #(.LINE_W(IMG_W), .NUM_LINES(IMG_H)) u_l1 (
    .clk     (clk),
    .reset   (reset),
    .valid_i (wen0_q),
    .pix_i   (pix0_q),
    .pix_o   (pixout1),
    .valid_o (w_en1)
  );

  pyr_down2x2 #(.LINE_W(IMG_W / 2), .NUM_LINES(IMG_H / 2)) u_l2 (
    .clk     (clk),
    .reset   (reset),
    .valid_i (w_en1),
    .pix_i   (pixout1),
    .pix_o   (pixout2),
    .valid_o (w_en2)
  );

endmodule

// File: tb/tb_pyramid_gen.sv
// Scoreboard bench for pyramid_gen on an 8x8 frame; reference model works on whole-frame arrays.
module tb_pyramid_gen;

  localparam int unsigned IMG_W = 8;
  localparam int unsigned IMG_H = 8;

`ifdef PYR_ROUND_EN
  localparam int L1_FIRST = 5;
  localparam int L2_BASE  = 14;
`else
  localparam int L1_FIRST = 4;
  localparam int L2_BASE  = 13;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        addr_en;
  logic [11:0] pixel_in;
  logic [7:0]  pixout0, pixout1, pixout2;
  logic        w_en0, w_en1, w_en2;

  always #5 clk = ~clk;

  pyramid_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr_en  (addr_en),
    .pixel_in (pixel_in),
    .pixout0  (pixout0),
    .pixout1  (pixout1),
    .pixout2  (pixout2),
    .w_en0    (w_en0),
    .w_en1    (w_en1),
    .w_en2    (w_en2)
  );

  typedef struct {
    logic [7:0] val;
    int         due;
  } exp_t;

  exp_t       q [3][$];
  logic [7:0] obs1 [$];
  logic [7:0] obs2 [$];
  int         cnt [3];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         mrow    = 0;
  int         mcol    = 0;
  int         f0 [IMG_H][IMG_W];
  int         f1 [IMG_H/2][IMG_W/2];

  function automatic int m_l0(input logic [11:0] p);
`ifdef PYR_ROUND_EN
    int v;
    v = (int'(p) + 8) / 16;
    return (v > 255) ? 255 : v;
`else
    return int'(p) / 16;
`endif
  endfunction

  function automatic int m_avg(input int s);
`ifdef PYR_ROUND_EN
    int v;
    v = (s + 2) / 4;
    return (v > 255) ? 255 : v;
`else
    return s / 4;
`endif
  endfunction

  // Reference model: record an accepted pixel and schedule every strobe it causes.
  task automatic model_push(input logic [11:0] p);
    exp_t e;
    int   s, r1, c1;
    f0[mrow][mcol] = m_l0(p);
    e.val = 8'(f0[mrow][mcol]); e.due = cyc + 1; q[0].push_back(e);
    if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
      s = f0[mrow-1][mcol-1] + f0[mrow-1][mcol] + f0[mrow][mcol-1] + f0[mrow][mcol];
      r1 = mrow / 2; c1 = mcol / 2;
      f1[r1][c1] = m_avg(s);
      e.val = 8'(f1[r1][c1]); e.due = cyc + 2; q[1].push_back(e);
      if ((r1 % 2 == 1) && (c1 % 2 == 1)) begin
        s = f1[r1-1][c1-1] + f1[r1-1][c1] + f1[r1][c1-1] + f1[r1][c1];
        e.val = 8'(m_avg(s)); e.due = cyc + 3; q[2].push_back(e);
      end
    end
    mcol++;
    if (mcol == int'(IMG_W)) begin
      mcol = 0; mrow++;
      if (mrow == int'(IMG_H)) mrow = 0;
    end
  endtask

  // One clock: compare strobes from the last edge against the scoreboard, then drive.
  task automatic cycle(input logic en, input logic [11:0] pix);
    logic       w [3];
    logic [7:0] p [3];
    exp_t       e;
    @(negedge clk);
    w[0] = w_en0; w[1] = w_en1; w[2] = w_en2;
    p[0] = pixout0; p[1] = pixout1; p[2] = pixout2;
    for (int l = 0; l < 3; l++) begin
      while (q[l].size() > 0 && q[l][0].due < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL L%0d_missing: no strobe at cycle %0d, required value %0d", l, q[l][0].due, q[l][0].val);
        void'(q[l].pop_front());
      end
      if (w[l]) begin
        cnt[l]++;
        n_tests++;
        if (q[l].size() == 0) begin
          n_fail++;
          $display("FAIL L%0d_spurious: strobe at cycle %0d value %0d, none required", l, cyc, p[l]);
        end else begin
          e = q[l].pop_front();
          if (p[l] !== e.val || cyc !== e.due) begin
            n_fail++;
            $display("FAIL L%0d_value: got %0d at cycle %0d, required %0d at cycle %0d", l, p[l], cyc, e.val, e.due);
          end
        end
        if (l == 1) obs1.push_back(p[l]);
        if (l == 2) obs2.push_back(p[l]);
      end
    end
    addr_en  = en;
    pixel_in = pix;
    if (en) model_push(pix);
    cyc++;
  endtask

  task automatic start_test();
    obs1.delete(); obs2.delete();
    for (int l = 0; l < 3; l++) cnt[l] = 0;
  endtask

  task automatic drain();
    repeat (5) cycle(1'b0, 12'h000);
    for (int l = 0; l < 3; l++) begin
      n_tests++;
      if (q[l].size() !== 0) begin
        n_fail++;
        $display("FAIL L%0d_drain: %0d strobes outstanding, required 0", l, q[l].size());
        q[l].delete();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; addr_en = 1'b0; pixel_in = 12'h000;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({pixout0, pixout1, pixout2} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_pix: got %h/%h/%h, required 0/0/0", pixout0, pixout1, pixout2);
    end
    n_tests++;
    if ({w_en0, w_en1, w_en2} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobe: got %b%b%b, required 000", w_en0, w_en1, w_en2);
    end
    reset = 1'b1;
  endtask

  task automatic test_ramp();
    int exp2 [4];
    exp2 = '{L2_BASE, L2_BASE + 4, L2_BASE + 32, L2_BASE + 36};
    start_test();
    for (int k = 0; k < 64; k++) cycle(1'b1, 12'(16 * k));
    drain();
    n_tests++;
    if (cnt[0] != 64 || cnt[1] != 16 || cnt[2] != 4) begin
      n_fail++;
      $display("FAIL ramp_counts: got %0d/%0d/%0d, required 64/16/4", cnt[0], cnt[1], cnt[2]);
    end
    n_tests++;
    if (obs1.size() == 0 || int'(obs1[0]) != L1_FIRST) begin
      n_fail++;
      $display("FAIL ramp_l1_first: got %0d, required %0d", (obs1.size() > 0) ? int'(obs1[0]) : -1, L1_FIRST);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (obs2.size() <= i || int'(obs2[i]) != exp2[i]) begin
        n_fail++;
        $display("FAIL ramp_l2_%0d: got %0d, required %0d", i, (obs2.size() > i) ? int'(obs2[i]) : -1, exp2[i]);
      end
    end
  endtask

  task automatic test_const();
    int bad;
    start_test();
    repeat (64) cycle(1'b1, 12'hFFF);
    drain();
    bad = 0;
    foreach (obs1[i]) if (obs1[i] !== 8'hFF) bad++;
    foreach (obs2[i]) if (obs2[i] !== 8'hFF) bad++;
    n_tests++;
    if (bad != 0 || pixout0 !== 8'hFF) begin
      n_fail++;
      $display("FAIL const_values: %0d non-255 outputs, pixout0 %0d, required 0 and 255", bad, pixout0);
    end
    n_tests++;
    if (cnt[0] != 64 || cnt[1] != 16 || cnt[2] != 4) begin
      n_fail++;
      $display("FAIL const_counts: got %0d/%0d/%0d, required 64/16/4", cnt[0], cnt[1], cnt[2]);
    end
  endtask

  task automatic test_gaps();
    int k;
    start_test();
    k = 0;
    for (int i = 0; k < 64; i++) begin
      if (i % 3 == 2) cycle(1'b0, 12'hABC);
      else begin
        cycle(1'b1, 12'(16 * k));
        k++;
      end
    end
    drain();
    n_tests++;
    if (cnt[0] != 64 || cnt[1] != 16 || cnt[2] != 4) begin
      n_fail++;
      $display("FAIL gaps_counts: got %0d/%0d/%0d, required 64/16/4", cnt[0], cnt[1], cnt[2]);
    end
    n_tests++;
    if (obs2.size() == 0 || int'(obs2[0]) != L2_BASE) begin
      n_fail++;
      $display("FAIL gaps_l2_first: got %0d, required %0d", (obs2.size() > 0) ? int'(obs2[0]) : -1, L2_BASE);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 20; k++) cycle(1'b1, 12'(16 * k));
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({pixout0, pixout1, pixout2} !== 24'h0 || {w_en0, w_en1, w_en2} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h/%h/%h strobes %b%b%b, required all 0",
               pixout0, pixout1, pixout2, w_en0, w_en1, w_en2);
    end
    for (int l = 0; l < 3; l++) q[l].delete();
    mrow = 0; mcol = 0;
    repeat (2) cycle(1'b0, 12'h000);
    reset = 1'b1;
    start_test();
    for (int k = 0; k < 64; k++) cycle(1'b1, 12'(16 * k));
    drain();
    n_tests++;
    if (cnt[0] != 64 || cnt[1] != 16 || cnt[2] != 4) begin
      n_fail++;
      $display("FAIL midreset_counts: got %0d/%0d/%0d, required 64/16/4", cnt[0], cnt[1], cnt[2]);
    end
    n_tests++;
    if (obs1.size() == 0 || int'(obs1[0]) != L1_FIRST) begin
      n_fail++;
      $display("FAIL midreset_l1_first: got %0d, required %0d", (obs1.size() > 0) ? int'(obs1[0]) : -1, L1_FIRST);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    start_test();
    for (int k = 0; k < 128; k++) cycle(1'b1, 12'(16 * (k % 64)));
    drain();
    n_tests++;
    if (cnt[0] != 128 || cnt[1] != 32 || cnt[2] != 8) begin
      n_fail++;
      $display("FAIL b2b_counts: got %0d/%0d/%0d, required 128/32/8", cnt[0], cnt[1], cnt[2]);
    end
    bad = 0;
    if (obs1.size() != 32 || obs2.size() != 8) bad = 1;
    else begin
      for (int i = 0; i < 16; i++) if (obs1[i] !== obs1[i+16]) bad++;
      for (int i = 0; i < 4; i++) if (obs2[i] !== obs2[i+4]) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL b2b_frames: %0d differing values between frames, required 0", bad);
    end
  endtask

  initial begin
    for (int l = 0; l < 3; l++) cnt[l] = 0;
    test_reset();
    test_ramp();
    test_const();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
